// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed scanner for a multi-digit 7-segment
// display. Walks one digit per REFRESH_DIV cycles and feeds its BCD code,
// decimal point and active-low anode to the downstream segment decoder.
// A shadow buffer is swapped into the active buffer only on the frame
// wrap, so a freshly loaded value is never shown half old / half new.
module display_scan_mux #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD        = 64,
  parameter int IDX_W       = $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [3:0]            bcd_out,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_start
);

  localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_C   = CNT_W'(DEAD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [3:0]       BLANK    = 4'hF;

  // Bit j set when digit j and every more-significant digit are zero with
  // no decimal point lit, i.e. digit j is a leading zero.
  function automatic logic [N_DIGITS-1:0] lead_zero_mask(
    input logic [4*N_DIGITS-1:0] dig,
    input logic [N_DIGITS-1:0]   dp
  );
    logic                run;
    logic [N_DIGITS-1:0] m;
    run = 1'b1;
    m   = '0;
    for (int j = N_DIGITS - 1; j >= 0; j--) begin
      run  = run && (dig[4*j +: 4] == 4'h0) && !dp[j];
      m[j] = run;
    end
    return m;
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] act_dig_q, act_dig_d, sh_dig_q, sh_dig_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic                  pend_q, pend_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0]   an_n_q, an_n_d;
  logic                  fs_q;
  logic                  last_slot_s, wrap_s, blank_s;
  logic [N_DIGITS-1:0]   lz_s;

  // Slot counter and digit index advance; wrap marks the frame boundary.
  always_comb begin
    last_slot_s = (cnt_q == CNT_LAST);
    wrap_s      = last_slot_s && (idx_q == IDX_LAST);
    if (last_slot_s) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
    end
  end

  // Double buffer: loads go to the shadow; the active copy only changes on
  // the wrap, taking the input directly when a load lands on that edge.
  always_comb begin
    act_dig_d = act_dig_q;
    act_dp_d  = act_dp_q;
    sh_dig_d  = sh_dig_q;
    sh_dp_d   = sh_dp_q;
    pend_d    = pend_q;
    if (load) begin
      sh_dig_d = digits_in;
      sh_dp_d  = dp_in;
    end else begin
      sh_dig_d = sh_dig_q;
      sh_dp_d  = sh_dp_q;
    end
    if (wrap_s && load) begin
      act_dig_d = digits_in;
      act_dp_d  = dp_in;
      pend_d    = 1'b0;
    end else if (wrap_s && pend_q) begin
      act_dig_d = sh_dig_q;
      act_dp_d  = sh_dp_q;
      pend_d    = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Output codes for the digit that will be current after this edge, so
  // index, code and anode all change together.
  always_comb begin
    lz_s    = lead_zero_mask(act_dig_d, act_dp_d);
    blank_s = blank_lz && (idx_d != '0) && lz_s[idx_d];
    if (blank_s) begin
      bcd_d  = BLANK;
      dp_n_d = 1'b1;
    end else begin
      bcd_d  = act_dig_d[{idx_d, 2'b00} +: 4];
      dp_n_d = ~act_dp_d[idx_d];
    end
    an_n_d = '1;
    if (cnt_d >= DEAD_C) begin
      an_n_d[idx_d] = 1'b0;
    end else begin
      an_n_d = '1;
    end
  end

  // State and registered outputs; reset aborts any scan in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      act_dig_q <= '0;
      act_dp_q  <= '0;
      sh_dig_q  <= '0;
      sh_dp_q   <= '0;
      pend_q    <= 1'b0;
      bcd_q     <= BLANK;
      dp_n_q    <= 1'b1;
      an_n_q    <= '1;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      sh_dig_q  <= sh_dig_d;
      sh_dp_q   <= sh_dp_d;
      pend_q    <= pend_d;
      bcd_q     <= bcd_d;
      dp_n_q    <= dp_n_d;
      an_n_q    <= an_n_d;
      fs_q      <= wrap_s;
    end
  end

  assign bcd_out     = bcd_q;
  assign dp_n        = dp_n_q;
  assign an_n        = an_n_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;

endmodule
